// File: rtl/psum_mem_arbiter.sv
// rtl/psum_mem_arbiter.sv - single-port partial-sum SRAM arbiter with write buffer and flush
module psum_mem_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_in,
  input  logic                            rd_req,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic                            rd_gnt,
  output logic                            rd_data_valid,
  output logic [DATA_W-1:0]               rd_data,
  input  logic                            wr_req,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            wr_ready,
  input  logic                            host_req,
  input  logic [ADDR_W-1:0]               host_addr,
  output logic                            host_gnt,
  output logic                            host_rdata_valid,
  output logic [DATA_W-1:0]               host_rdata,
  output logic                            stall,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_count,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;
  typedef enum logic [1:0] {G_NONE, G_DRAIN, G_RD, G_HOST} grant_t;

  logic [ADDR_W-1:0]     wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]     wb_data [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] wb_valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  rr_host_first;
  logic                  rr_toggle;
  state_t                state;
  state_t                state_next;
  grant_t                grant;
  logic                  enq;
  logic                  deq;
  logic                  buf_full;
  logic                  buf_busy;
  logic                  rd_hazard;
  logic                  host_hazard;

  assign buf_full   = (count == CNT_W'(WBUF_DEPTH));
  assign buf_busy   = (count != '0);
  assign wr_ready   = (count < CNT_W'(WBUF_DEPTH));
  assign enq        = wr_req && wr_ready;
  assign deq        = (grant == G_DRAIN);
  assign count_next = count + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, deq};
  assign wbuf_count = count;

  // SRAM read data has one cycle latency, so it lines up with the registered valids
  assign rd_data    = mem_rdata;
  assign host_rdata = mem_rdata;

  // Address match of both readers against every buffered (not yet drained) write
  always_comb begin
    rd_hazard   = 1'b0;
    host_hazard = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (wb_valid[i] && (wb_addr[i] == rd_addr))   rd_hazard   = 1'b1;
      if (wb_valid[i] && (wb_addr[i] == host_addr)) host_hazard = 1'b1;
    end
    rd_hazard   = rd_hazard && rd_req;
    host_hazard = host_hazard && host_req;
  end

  // One SRAM access per cycle; drains are forced whenever a reader depends on buffered data
  always_comb begin
    grant     = G_NONE;
    rr_toggle = 1'b0;
    if (rst_in) begin
      grant = G_NONE;
    end else if (buf_full) begin
      grant = G_DRAIN;
    end else if (rd_req && !rd_hazard) begin
      grant = G_RD;
    end else if (rd_req) begin
      grant = G_DRAIN;
    end else if (state == S_FLUSH) begin
      if (buf_busy) grant = G_DRAIN;
    end else if (host_req && !host_hazard && buf_busy) begin
      rr_toggle = 1'b1;
      grant     = rr_host_first ? G_HOST : G_DRAIN;
    end else if (host_req && host_hazard) begin
      grant = G_DRAIN;
    end else if (host_req) begin
      grant = G_HOST;
    end else if (buf_busy) begin
      grant = G_DRAIN;
    end
  end

  // SRAM port driven straight from the grant decision
  always_comb begin
    rd_gnt    = (grant == G_RD);
    host_gnt  = (grant == G_HOST);
    stall     = rd_req && (grant != G_RD);
    mem_en    = (grant != G_NONE);
    mem_we    = deq;
    mem_wdata = wb_data[head];
    case (grant)
      G_DRAIN: mem_addr = wb_addr[head];
      G_RD:    mem_addr = rd_addr;
      G_HOST:  mem_addr = host_addr;
      default: mem_addr = '0;
    endcase
  end

  // Flush tracking: done is reported in the cycle the buffer becomes empty
  always_comb begin
    state_next = state;
    flush_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_req) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!rst_in && (count_next == '0)) begin
          state_next = S_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Write buffer payload; entries are qualified by wb_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr[tail] <= wr_addr;
      wb_data[tail] <= wr_data;
    end
  end

  // Control state: FIFO pointers, occupancy, round-robin token, flush state, read valids
  always_ff @(posedge clk) begin
    if (rst_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      wb_valid         <= '0;
      rr_host_first    <= 1'b1;
      state            <= S_IDLE;
      rd_data_valid    <= 1'b0;
      host_rdata_valid <= 1'b0;
    end else begin
      if (deq) begin
        wb_valid[head] <= 1'b0;
        head           <= head + PTR_W'(1);
      end
      if (enq) begin
        wb_valid[tail] <= 1'b1;
        tail           <= tail + PTR_W'(1);
      end
      if (rr_toggle) rr_host_first <= !rr_host_first;
      count            <= count_next;
      state            <= state_next;
      rd_data_valid    <= rd_gnt;
      host_rdata_valid <= host_gnt;
    end
  end

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// tb/tb_psum_mem_arbiter.sv - scoreboard bench for psum_mem_arbiter
module tb_psum_mem_arbiter;

  logic        clk;
  logic        rst_in;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_gnt;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        host_req;
  logic [16:0] host_addr;
  logic        host_gnt;
  logic        host_rdata_valid;
  logic [31:0] host_rdata;
  logic        stall;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  wbuf_count;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [16:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_host[$];
  logic [31:0] sram [logic [16:0]];

  int n_cmp = 0;
  int n_bad = 0;

  psum_mem_arbiter dut (
    .clk(clk), .rst_in(rst_in),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_rdata_valid(host_rdata_valid), .host_rdata(host_rdata),
    .stall(stall), .flush_req(flush_req), .flush_done(flush_done),
    .wbuf_count(wbuf_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port SRAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] = mem_wdata;
      else        mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a write or read data
  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      chk("sram write expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("sram write addr", 32'(mem_addr), 32'(w.a));
        chk("sram write data", mem_wdata, w.d);
      end
    end
    if (rd_data_valid === 1'b1) begin
      chk("rd valid expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
    end
    if (host_rdata_valid === 1'b1) begin
      chk("host valid expected", 32'(exp_host.size() != 0), 32'd1);
      if (exp_host.size() != 0) chk("host_rdata", host_rdata, exp_host.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 0; wr_req = 0; host_req = 0; flush_req = 0;
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
    wr_req  = 1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic drain_wait();
    for (int k = 0; k < 20 && wbuf_count != 3'd0; k++) cyc();
    chk("drain complete", 32'(wbuf_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_in = 1; idle_inputs();
    rd_addr = 0; wr_addr = 0; wr_data = 0; host_addr = 0;
    repeat (3) cyc();
    rst_in = 0;

    // reset then idle
    @(negedge clk);
    chk("reset wbuf_count", 32'(wbuf_count), 32'd0);
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset rd_data_valid", 32'(rd_data_valid), 32'd0);
    chk("reset host_rdata_valid", 32'(host_rdata_valid), 32'd0);
    chk("reset flush_done", 32'(flush_done), 32'd0);
    cyc();

    // single write drains on the following cycle
    push_wr(17'h00010, 32'h0000DEAD);
    @(negedge clk); chk("single wr enq mem_en", 32'(mem_en), 32'd0);
    cyc(); wr_req = 0;
    @(negedge clk);
    chk("single wr drain mem_we", 32'(mem_we), 32'd1);
    chk("single wr drain mem_addr", 32'(mem_addr), 32'h00010);
    chk("single wr count", 32'(wbuf_count), 32'd1);
    cyc();
    @(negedge clk);
    chk("single wr count back", 32'(wbuf_count), 32'd0);
    chk("single wr idle mem_en", 32'(mem_en), 32'd0);
    cyc();

    // fill buffer behind continuous non-conflicting reads
    for (int i = 0; i < 4; i++) begin
      push_wr(17'h00100 + 17'(i), 32'h00001000 + 32'(i));
      rd_req = 1; rd_addr = 17'h00200 + 17'(i); exp_rd.push_back(32'h0);
      @(negedge clk); chk("fill rd_gnt", 32'(rd_gnt), 32'd1);
      cyc();
    end
    wr_req = 0; rd_addr = 17'h00204;
    @(negedge clk);
    chk("full count", 32'(wbuf_count), 32'd4);
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    chk("full stall", 32'(stall), 32'd1);
    chk("full rd_gnt", 32'(rd_gnt), 32'd0);
    chk("full drain mem_we", 32'(mem_we), 32'd1);
    cyc();
    exp_rd.push_back(32'h0);
    @(negedge clk); chk("after drain rd_gnt", 32'(rd_gnt), 32'd1);
    cyc(); rd_req = 0;
    drain_wait();

    // read-after-write hazard; enqueue alongside the forced drain keeps count
    push_wr(17'h00123, 32'hCAFE0123);
    cyc();
    push_wr(17'h00124, 32'hBEEF0124);
    rd_req = 1; rd_addr = 17'h00123; exp_rd.push_back(32'hCAFE0123);
    @(negedge clk);
    chk("hazard stall", 32'(stall), 32'd1);
    chk("hazard rd_gnt", 32'(rd_gnt), 32'd0);
    chk("hazard drain addr", 32'(mem_addr), 32'h00123);
    cyc(); wr_req = 0;
    @(negedge clk);
    chk("hazard count kept", 32'(wbuf_count), 32'd1);
    chk("hazard cleared rd_gnt", 32'(rd_gnt), 32'd1);
    chk("hazard cleared stall", 32'(stall), 32'd0);
    cyc(); rd_req = 0;
    drain_wait();
    host_req = 1; host_addr = 17'h00123; exp_host.push_back(32'hCAFE0123);
    @(negedge clk); chk("host alone gnt", 32'(host_gnt), 32'd1);
    cyc(); host_req = 0;

    // round robin host vs drain, token fresh from reset
    rst_in = 1; cyc(); rst_in = 0;
    push_wr(17'h00300, 32'h00003000);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      push_wr(17'h00300 + 17'(k), 32'h00003000 + 32'(k));
      host_req = 1; host_addr = 17'h00100;
      if (k % 2 == 1) exp_host.push_back(32'h00001000);
      @(negedge clk);
      chk("rr host_gnt", 32'(host_gnt), 32'(k % 2 == 1));
      chk("rr drain", 32'(mem_we), 32'(k % 2 == 0));
      cyc();
    end
    idle_inputs();
    drain_wait();

    // flush with three entries; host is held off until done
    for (int i = 0; i < 3; i++) begin
      push_wr(17'h00400 + 17'(i), 32'h00004000 + 32'(i));
      rd_req = 1; rd_addr = 17'h00210 + 17'(i); exp_rd.push_back(32'h0);
      flush_req = (i == 2);
      @(negedge clk); chk("flush fill rd_gnt", 32'(rd_gnt), 32'd1);
      cyc();
    end
    idle_inputs();
    host_req = 1; host_addr = 17'h00100;
    for (int j = 3; j <= 5; j++) begin
      @(negedge clk);
      chk("flush drain", 32'(mem_we), 32'd1);
      chk("flush host blocked", 32'(host_gnt), 32'd0);
      chk("flush_done timing", 32'(flush_done), 32'(j == 5));
      cyc();
    end
    exp_host.push_back(32'h00001000);
    @(negedge clk);
    chk("post flush host_gnt", 32'(host_gnt), 32'd1);
    chk("post flush done low", 32'(flush_done), 32'd0);
    cyc(); host_req = 0;

    // flush on an empty buffer completes next cycle
    flush_req = 1;
    @(negedge clk); chk("empty flush req cycle", 32'(flush_done), 32'd0);
    cyc(); flush_req = 0;
    @(negedge clk); chk("empty flush done", 32'(flush_done), 32'd1);
    cyc();
    @(negedge clk); chk("empty flush done once", 32'(flush_done), 32'd0);
    cyc();

    // reset in the middle of a flush discards the rest
    for (int i = 0; i < 3; i++) begin
      wr_req = 1; wr_addr = 17'h00500 + 17'(i); wr_data = 32'h00005000 + 32'(i);
      if (i == 0) begin
        wr_t w;
        w.a = wr_addr; w.d = wr_data;
        exp_wr.push_back(w);
      end
      rd_req = 1; rd_addr = 17'h00220 + 17'(i); exp_rd.push_back(32'h0);
      flush_req = (i == 2);
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    chk("midflush drain addr", 32'(mem_addr), 32'h00500);
    chk("midflush done low", 32'(flush_done), 32'd0);
    cyc();
    rst_in = 1;
    @(negedge clk);
    chk("reset cycle mem_en", 32'(mem_en), 32'd0);
    chk("reset cycle flush_done", 32'(flush_done), 32'd0);
    cyc();
    rst_in = 0;
    @(negedge clk);
    chk("midflush reset count", 32'(wbuf_count), 32'd0);
    chk("midflush reset mem_en", 32'(mem_en), 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (flush_done === 1'b1) pulses++;
    end
    chk("no flush_done after reset", 32'(pulses), 32'd0);

    repeat (3) cyc();
    chk("write queue empty", 32'(exp_wr.size()), 32'd0);
    chk("read queue empty", 32'(exp_rd.size()), 32'd0);
    chk("host queue empty", 32'(exp_host.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_mem_arbiter.md
Name: psum_mem_arbiter

Overview:
- Shares the single-port partial-sum SRAM between three requesters:
  - controller read port: fetches the accumulator for the current (x, y, ch_out);
  - controller write port: writes back partial sums, buffered in a small write FIFO;
  - host readback port.
- Grants exactly one SRAM access per cycle.
- Enforces read-after-write ordering against buffered writes.
- Provides a flush handshake so the controller can drain all pending writes before reporting done.

Parameters:
- ADDR_W, 17, SRAM address width ({x[5:0], y[5:0], ch_out[4:0]}).
- DATA_W, 32, partial-sum width.
- WBUF_DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous reset, active-high
- rd_req  in  1  controller read request
- rd_addr  in  ADDR_W  controller read address
- rd_gnt  out  1  read granted this cycle (combinational)
- rd_data_valid  out  1  rd_data valid (registered)
- rd_data  out  DATA_W  read data
- wr_req  in  1  controller write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write buffer can accept
- host_req  in  1  host read request
- host_addr  in  ADDR_W  host read address
- host_gnt  out  1  host read granted this cycle (combinational)
- host_rdata_valid  out  1  host_rdata valid (registered)
- host_rdata  out  DATA_W  host read data
- stall  out  1  rd_req pending but not granted; controller deasserts ready
- flush_req  in  1  request to drain the write buffer
- flush_done  out  1  one-cycle pulse: buffer empty after flush
- wbuf_count  out  $clog2(WBUF_DEPTH)+1  entries held
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, 1-cycle latency

Behaviour:
- Reset (rst_in sampled high at a clk edge):
  - wbuf_count = 0; pointers = 0; rr_host_first = 1; state = IDLE.
  - rd_data_valid, host_rdata_valid and flush_done = 0.
  - Buffered writes are discarded.
- Write buffer (circular FIFO):
  - wr_ready = (wbuf_count < WBUF_DEPTH), taken from the registered count.
  - Enqueue when wr_req && wr_ready.
  - Enqueue and drain may occur in the same cycle; the count is then unchanged.
  - A drain writes the head entry: mem_en = 1, mem_we = 1.
- Hazard:
  - rd_hazard = rd_req && rd_addr matches the address of any valid buffered entry.
  - host_hazard is computed the same way for host_addr.
  - A write being enqueued in the current cycle is not compared. A same-cycle read to that address returns the pre-write value.
- Per-cycle grant priority (exactly one, or none):
  1. wbuf_count == WBUF_DEPTH: drain.
  2. rd_req && !rd_hazard: controller read.
  3. rd_req && rd_hazard: drain.
  4. state == FLUSH && count > 0: drain.
  5. host_req && !host_hazard and count > 0: round-robin between host and drain.
     - rr_host_first chooses the winner.
     - The token passes to the loser after each contested grant.
  6. host_req && host_hazard: drain.
  7. host_req alone: host.
  8. count > 0: drain.
  9. Otherwise: mem_en = 0.
- Host is never granted in FLUSH.
- stall = rd_req && !rd_gnt.
- Read outputs:
  - mem_we = 0 for reads.
  - One cycle after a grant, the matching *_valid is 1 and *_rdata = mem_rdata.
  - Back-to-back grants give back-to-back valids.
- Flush state machine:
  - IDLE -> FLUSH on flush_req.
  - FLUSH -> IDLE when wbuf_count == 0 at the end of a cycle; flush_done pulses high for exactly that one cycle.
  - If the buffer is already empty when flush_req arrives, flush_done pulses on the following cycle.
  - flush_req held high after done re-enters FLUSH.
  - Writes may still be enqueued during FLUSH; completion waits for them.
- The mem_* outputs are combinational from the grant decision.

Test Plan:
- Reset then idle: wbuf_count = 0, wr_ready = 1, mem_en = 0, all valids 0.
- Write 0x00010 = 0xDEAD, no other requests: next cycle mem_we = 1, mem_addr = 0x00010, mem_wdata = 0xDEAD; then count returns to 0.
- Enqueue 4 writes while rd_req is held high to non-matching addresses:
  - rd_gnt = 1 each cycle; count reaches 4 and wr_ready = 0.
  - The next cycle drains, with stall = 1 and rd_gnt = 0.
- Buffer holds a write to 0x00123 and rd_req targets 0x00123:
  - stall = 1 until the drain completes.
  - The read is then granted; rd_data_valid is 1 one cycle later with the written value.
- Host and drain contend continuously, one buffered entry refilled each cycle: grants alternate host/drain starting with host after reset.
- flush_req with 3 entries buffered:
  - 3 consecutive drains; host_req is ignored.
  - flush_done is high for 1 cycle at the end.
  - Assert rst_in mid-flush: count = 0, flush_done never pulses.
